// File: rtl/vga_timing_pkg.sv
// SVGA 800x600@60 Hz (40 MHz pixel clock) line and frame timing constants.
// Shared by the horizontal/vertical counters and the sync/blank decode.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned H_FP     = 40;
   localparam int unsigned H_SYNC   = 128;
   localparam int unsigned H_BP     = 88;
   localparam int unsigned H_TOTAL  = 1056;
   localparam int unsigned H_CNT_W  = 11;

   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned V_FP     = 1;
   localparam int unsigned V_SYNC   = 4;
   localparam int unsigned V_BP     = 23;
   localparam int unsigned V_TOTAL  = 628;

endpackage

// File: rtl/vga_h_counter.sv
// Free-running modulo-PERIOD position counter with terminal-count flag.
// Used for the horizontal pixel count and, re-parameterised, the line count.
module vga_h_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned WIDTH  = H_CNT_W,
   parameter int unsigned PERIOD = H_TOTAL
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

   if (PERIOD < 2 || PERIOD > (1 << WIDTH)) begin : g_bad_param
      $error("vga_h_counter: PERIOD must lie in 2 .. 2**WIDTH");
   end

   // Power-up value keeps count defined when rst is released before the first edge.
   logic [WIDTH-1:0] count_q = '0;
   logic [WIDTH-1:0] count_d;

   // >= rather than == also recovers from any out-of-range value.
   always_comb begin
      count_d = count_q + WIDTH'(1);
      if (count_q >= LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == LAST);

endmodule

// File: tb/tb_vga_h_counter.sv
// Scoreboard bench for vga_h_counter: horizontal (1056) and vertical-style (628) instances.
`timescale 1ns/1ps
module tb_vga_h_counter;
   import vga_timing_pkg::*;

   localparam int H_P = 1056;
   localparam int V_P = 628;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] h_count;
   logic        h_tc;
   logic [9:0]  v_count;
   logic        v_tc;

   vga_h_counter u_dut (
      .clk   (clk),
      .rst   (rst),
      .count (h_count),
      .tc    (h_tc)
   );

   vga_h_counter #(.WIDTH(10), .PERIOD(V_TOTAL)) u_dut_v (
      .clk   (clk),
      .rst   (rst),
      .count (v_count),
      .tc    (v_tc)
   );

   // First rising edge at 12.5 ns, 40 MHz.
   initial begin
      #12.5;
      forever begin
         clk = 1'b1;
         #12.5;
         clk = 1'b0;
         #12.5;
      end
   end

   typedef struct {
      int h_cnt;
      int h_tc;
      int v_cnt;
      int v_tc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   mdl_h    = 0;
   int   mdl_v    = 0;
   bit   chk_each = 1'b1;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive rst for one edge, push the predicted post-edge state, then compare.
   task automatic step(input logic rst_val);
      exp_t e;
      exp_t o;
      rst = rst_val;
      if (rst_val) begin
         mdl_h = 0;
         mdl_v = 0;
      end else begin
         mdl_h = (mdl_h == H_P - 1) ? 0 : mdl_h + 1;
         mdl_v = (mdl_v == V_P - 1) ? 0 : mdl_v + 1;
      end
      e.h_cnt = mdl_h;
      e.h_tc  = (mdl_h == H_P - 1) ? 1 : 0;
      e.v_cnt = mdl_v;
      e.v_tc  = (mdl_v == V_P - 1) ? 1 : 0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      o = sb_q.pop_front();
      if (chk_each) begin
         check_val("h_count", longint'(h_count), longint'(o.h_cnt));
         check_val("h_tc",    longint'(h_tc),    longint'(o.h_tc));
         check_val("v_count", longint'(v_count), longint'(o.v_cnt));
         check_val("v_tc",    longint'(v_tc),    longint'(o.v_tc));
      end
   endtask

   int wraps;
   int tc_hi;
   int max_h;
   int prev_h;
   int v_pulses;
   int v_first;
   int v_second;

   initial begin
      // Power-up: no edge has sampled rst, count must already be 0.
      #1;
      check_val("pwrup_count", longint'(h_count), 0);
      check_val("pwrup_tc", longint'(h_tc), 0);
      check_val("pwrup_known", longint'($isunknown({h_count, h_tc, v_count, v_tc})), 0);
      #9;
      rst = 1'b0;
      #1;
      check_val("pre_edge_count", longint'(h_count), 0);

      // Free run from 0; first edge gives 1.
      step(1'b0);
      check_val("first_edge", longint'(h_count), 1);
      for (int i = 0; i < 1054; i++) step(1'b0);
      check_val("at_last_cnt", longint'(h_count), 1055);
      check_val("at_last_tc", longint'(h_tc), 1);
      step(1'b0);
      check_val("wrap1_cnt", longint'(h_count), 0);
      check_val("wrap1_tc", longint'(h_tc), 0);
      for (int i = 0; i < 1055; i++) step(1'b0);
      check_val("pre_wrap2_tc", longint'(h_tc), 1);
      step(1'b0);
      check_val("wrap2_cnt", longint'(h_count), 0);

      // Mid-line reset held for three edges.
      for (int i = 0; i < 500; i++) step(1'b0);
      check_val("mid_cnt", longint'(h_count), 500);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check_val("mid_rst_cnt", longint'(h_count), 0);
         check_val("mid_rst_tc", longint'(h_tc), 0);
      end
      step(1'b0);
      check_val("mid_release", longint'(h_count), 1);

      // Reset landing on terminal count.
      for (int i = 0; i < 1054; i++) step(1'b0);
      check_val("tc_before_rst", longint'(h_tc), 1);
      step(1'b1);
      check_val("rst_at_tc_cnt", longint'(h_count), 0);
      check_val("rst_at_tc_tc", longint'(h_tc), 0);

      // Long run from 0: 1098 edges, exactly one wrap and one tc cycle.
      wraps  = 0;
      tc_hi  = 0;
      max_h  = 0;
      prev_h = int'(h_count);
      for (int i = 0; i < 1098; i++) begin
         step(1'b0);
         if (int'(h_count) > max_h) max_h = int'(h_count);
         if (int'(h_count) < prev_h) wraps++;
         if (h_tc) tc_hi++;
         prev_h = int'(h_count);
      end
      check_val("long_wraps", wraps, 1);
      check_val("long_tc_cycles", tc_hi, 1);
      check_val("long_in_range", (max_h < H_P) ? 1 : 0, 1);
      check_val("long_end_cnt", longint'(h_count), 1098 - H_P);

      // Vertical-style instance: tc spacing of exactly 628 edges.
      step(1'b1);
      chk_each  = 1'b0;
      v_pulses  = 0;
      v_first   = -1;
      v_second  = -1;
      for (int i = 1; i <= 1300; i++) begin
         step(1'b0);
         if (v_tc) begin
            v_pulses++;
            if (v_first < 0) v_first = i;
            else if (v_second < 0) v_second = i;
            check_val("v_tc_at_627", longint'(v_count), 627);
         end
         if (i == 628) check_val("v_wrap_cnt", longint'(v_count), 0);
      end
      check_val("v_pulses", v_pulses, 2);
      check_val("v_first_pulse", v_first, 627);
      check_val("v_pulse_spacing", v_second - v_first, 628);
      check_val("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/vga_h_counter.md
Name: vga_h_counter

Overview:
- Free-running horizontal pixel counter for the VGA timing path. Target mode is SVGA 800x600@60 Hz with a 40 MHz pixel clock.
- Counts pixel clocks across one full line (active + front porch + sync + back porch), 1056 clocks total, then wraps to 0.
- Downstream comparator and SR flip-flop blocks decode `count` into sync and blanking windows.

Parameters:
- WIDTH, 11, bit width of `count`. Must satisfy 2^WIDTH >= PERIOD.
- PERIOD, 1056, counts per line. `count` spans 0 .. PERIOD-1.

Ports:
- clk  input  1  pixel clock, 40 MHz nominal; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- count  output  WIDTH  current pixel position within the line, registered
- tc  output  1  terminal count; high while count == PERIOD-1

Behaviour:
- Single clock domain, one register `count[WIDTH-1:0]`. No enable; the counter advances on every clock.
- Reset is synchronous and active-high: on a rising clk edge with rst=1, count <= 0. Reset has priority over counting.
- The register also carries a power-up/initial value of 0. Reason: the system bench deasserts rst before the first clock edge, and count must still be 0 (never X) from time zero.
- Normal operation, at each rising edge with rst=0:
  - if count == PERIOD-1, count <= 0 (wrap)
  - otherwise count <= count + 1
- Sequence: 0,1,2,...,1055,0,1,... Period is exactly PERIOD clocks. The value PERIOD (1056) never appears on count.
- tc is combinational from count: tc = (count == PERIOD-1). It is high for exactly one clock per line, coincident with count=1055.
- Latency:
  - count updates one clock after the edge that samples it.
  - After rst is released, the first edge with rst=0 produces count=1.
- Reset mid-line: rst asserted at any count forces count=0 on the next edge. Counting resumes from 0 on the first edge after deassertion.
- rst held high: count stays 0 and tc stays 0.
- Defensive rule: if count is ever >= PERIOD (unreachable in normal operation), the next edge loads 0.
- Arithmetic:
  - The increment is WIDTH bits wide with no carry-out.
  - The wrap compare uses the constant PERIOD-1 at WIDTH bits.
  - Elaboration check: PERIOD >= 2 and PERIOD <= 2^WIDTH.

Decomposition:
- Shared package vga_timing_pkg holds the SVGA 800x600@60 line timing constants:
  - H_ACTIVE=800
  - H_FP=40
  - H_SYNC=128
  - H_BP=88
  - H_TOTAL=1056
  - H_CNT_W=11
- The package also holds the matching vertical constants:
  - V_ACTIVE=600
  - V_FP=1
  - V_SYNC=4
  - V_BP=23
  - V_TOTAL=628
- Parameter defaults come from H_TOTAL and H_CNT_W.
- No sub-module. Sync and blanking decode stays in the existing comparator/srff blocks.
- The vertical line counter is a second instance of this block with PERIOD=V_TOTAL. Its advance is gated at a higher level, outside this block.

Test Plan:
- Power-up, rst=1 for 10 ns, first clk edge at 12.5 ns (rst already 0): count is 0 before the first edge, then 1 after it. No X at any time.
- Free run from reset: after N edges count == N for N <= 1055. At count=1055, tc=1. The next edge gives count=0, tc=0. The second wrap occurs exactly 1056 edges later.
- Mid-line reset: run to count=500, hold rst=1 for 3 edges. count reads 0 for all 3 edges, then 1 on the first edge after release.
- Reset at terminal count: assert rst while count=1055. Next count is 0, same as the wrap value, and tc drops.
- Parameter sweep: PERIOD=628, WIDTH=10. count wraps 627 -> 0 and tc pulses once per 628 clocks.
- Long run: 27,469 ns at 40 MHz (~1098 edges). Exactly one wrap; count is never >= 1056; tc is high for exactly one cycle.
